// File: rtl/core5_oci_trace_pkg.sv
// Shared trace definitions for the OCI direct-compressed-trace (DCT) path:
// frame/packet geometry, packet record and trace frame encodings.
package core5_oci_trace_pkg;

    localparam int DCT_FRAME_W    = 2;
    localparam int DCT_MAX_FRAMES = 15;
    localparam int DCT_BUF_W      = 30;
    localparam int DCT_CNT_W      = 4;

    localparam logic [DCT_CNT_W-1:0] DCT_CNT_FULL = DCT_CNT_W'(DCT_MAX_FRAMES);

    localparam logic [DCT_FRAME_W-1:0] DCT_FRM_NONE = 2'b00;
    localparam logic [DCT_FRAME_W-1:0] DCT_FRM_SEQ  = 2'b01;
    localparam logic [DCT_FRAME_W-1:0] DCT_FRM_TKN  = 2'b10;
    localparam logic [DCT_FRAME_W-1:0] DCT_FRM_EXC  = 2'b11;

    typedef struct packed {
        logic [DCT_BUF_W-1:0] buffer;
        logic [DCT_CNT_W-1:0] count;
        logic                 ovf;
    } dct_pkt_t;

endpackage

// File: rtl/core5_oci_dct_outreg.sv
// Single-entry valid/ready holding register for DCT packets. A load is only
// issued while the entry is empty or draining, so load and drain may coincide.
module core5_oci_dct_outreg
    import core5_oci_trace_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_buffer,
    input  logic [DCT_CNT_W-1:0] load_count,
    input  logic                 load_ovf,
    input  logic                 pkt_ready,
    output logic                 pkt_valid,
    output logic [DCT_BUF_W-1:0] pkt_buffer,
    output logic [DCT_CNT_W-1:0] pkt_count,
    output logic                 pkt_ovf
);

    logic     valid_q, valid_d;
    dct_pkt_t pkt_q, pkt_d;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (load) begin
            valid_d = 1'b1;
            pkt_d   = '{buffer: load_buffer, count: load_count, ovf: load_ovf};
        end else if (pkt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign pkt_valid  = valid_q;
    assign pkt_buffer = pkt_q.buffer;
    assign pkt_count  = pkt_q.count;
    assign pkt_ovf    = pkt_q.ovf;

endmodule

// File: rtl/core5_oci_dct_packer.sv
// Packs 2-bit trace frames into 30-bit DCT packets, double-buffered against the
// consumer. Define CORE5_OCI_DCT_DROP_CNT_EN to add the drop_count output.
module core5_oci_dct_packer
    import core5_oci_trace_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_valid,
    input  logic [DCT_FRAME_W-1:0] frame_data,
    input  logic                   flush,
    input  logic                   pkt_ready,
    output logic                   pkt_valid,
    output logic [DCT_BUF_W-1:0]   dct_buffer,
    output logic [DCT_CNT_W-1:0]   dct_count,
    output logic                   pkt_ovf
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    logic [DCT_BUF_W-1:0] acc_q, acc_d, acc_nx;
    logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic                 flush_pend_q, flush_pend_d;
    logic                 ovf_sticky_q, ovf_sticky_d;

    logic                 acc_full, out_free, close, drop, load;
    logic [DCT_BUF_W-1:0] load_buffer;
    logic [DCT_CNT_W-1:0] load_count;

    assign acc_full = (cnt_q == DCT_CNT_FULL);
    assign out_free = !pkt_valid || pkt_ready;
    assign acc_nx   = frame_valid ? {acc_q[DCT_BUF_W-DCT_FRAME_W-1:0], frame_data} : acc_q;
    assign cnt_nx   = cnt_q + DCT_CNT_W'(frame_valid);
    assign close    = (cnt_nx == DCT_CNT_FULL) || ((flush || flush_pend_q) && (cnt_nx != '0));
    assign drop     = acc_full && !out_free && frame_valid;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        ovf_sticky_d = ovf_sticky_q;
        load         = 1'b0;
        load_buffer  = acc_nx;
        load_count   = cnt_nx;
        if (acc_full) begin
            // A full accumulator ships as-is; an incoming frame starts the next packet.
            load_buffer = acc_q;
            load_count  = cnt_q;
            if (out_free) begin
                load         = 1'b1;
                acc_d        = frame_valid ? DCT_BUF_W'(frame_data) : '0;
                cnt_d        = DCT_CNT_W'(frame_valid);
                flush_pend_d = frame_valid && flush;
                ovf_sticky_d = 1'b0;
            end else if (drop) begin
                ovf_sticky_d = 1'b1;
            end
        end else if (close && out_free) begin
            load         = 1'b1;
            acc_d        = '0;
            cnt_d        = '0;
            flush_pend_d = 1'b0;
            ovf_sticky_d = 1'b0;
        end else begin
            acc_d = acc_nx;
            cnt_d = cnt_nx;
            if (close) begin
                flush_pend_d = flush_pend_q || flush;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    core5_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_buffer (load_buffer),
        .load_count  (load_count),
        .load_ovf    (ovf_sticky_q),
        .pkt_ready   (pkt_ready),
        .pkt_valid   (pkt_valid),
        .pkt_buffer  (dct_buffer),
        .pkt_count   (dct_count),
        .pkt_ovf     (pkt_ovf)
    );

`ifdef CORE5_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_core5_oci_dct_packer.sv
// Self-checking bench for core5_oci_dct_packer: directed packet scenarios plus
// randomized traffic against a queue-based packet model.
module tb_core5_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_valid;
    logic [1:0]  frame_data;
    logic        flush;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_ovf;
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    always #5 clk = ~clk;

    core5_oci_dct_packer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .flush       (flush),
        .pkt_ready   (pkt_ready),
        .pkt_valid   (pkt_valid),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .pkt_ovf     (pkt_ovf)
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pending frames as a queue, oldest first.
    logic [1:0]  m_acc[$];
    bit          m_fp, m_ovf, m_valid, m_pov;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    int          m_drops;

    function automatic logic [29:0] pack_frames();
        logic [29:0] b = '0;
        foreach (m_acc[i]) b = (b << 2) | 30'(m_acc[i]);
        return b;
    endfunction

    function automatic logic [35:0] dut_vec();
        return {pkt_valid, pkt_ovf, dct_count, dct_buffer};
    endfunction

    function automatic logic [35:0] mdl_vec();
        return {m_valid, m_pov, m_cnt, m_buf};
    endfunction

    task automatic model_reset();
        m_acc.delete();
        m_fp = 0; m_ovf = 0; m_valid = 0; m_pov = 0;
        m_buf = '0; m_cnt = '0; m_drops = 0;
    endtask

    task automatic model_step();
        bit          free, ld;
        logic [29:0] b;
        logic [3:0]  c;
        bit          o;
        free = !m_valid || pkt_ready;
        ld = 0; b = '0; c = '0; o = 0;
        if (m_acc.size() == 15) begin
            if (free) begin
                ld = 1; b = pack_frames(); c = 4'd15; o = m_ovf;
                m_ovf = 0;
                m_acc.delete();
                if (frame_valid) m_acc.push_back(frame_data);
                m_fp = frame_valid && flush;
            end else if (frame_valid) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end else begin
            if (frame_valid) m_acc.push_back(frame_data);
            if (m_acc.size() == 15 || ((flush || m_fp) && m_acc.size() > 0)) begin
                if (free) begin
                    ld = 1; b = pack_frames(); c = 4'(m_acc.size()); o = m_ovf;
                    m_ovf = 0; m_fp = 0;
                    m_acc.delete();
                end else begin
                    m_fp = m_fp || flush;
                end
            end
        end
        if (ld) begin
            m_valid = 1; m_buf = b; m_cnt = c; m_pov = o;
        end else if (pkt_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit fv, input logic [1:0] fd, input bit fl, input bit rdy);
        frame_valid = fv; frame_data = fd; flush = fl; pkt_ready = rdy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(0, 2'b00, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (dut_vec() !== 36'h0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
        else n_pass++;
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
        n_total++;
        if (drop_count !== 16'h0) $display("FAIL reset_drop_count: got %h want 0", drop_count);
        else n_pass++;
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_full_packet();
        for (int i = 0; i < 15; i++) begin
            set_in(1, 2'b01, 0, 1);
            cycle();
            n_total++;
            if (dut_vec() !== mdl_vec()) $display("FAIL full_model cyc%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else n_pass++;
        end
        n_total++;
        if ({pkt_valid, dct_count, pkt_ovf} !== {1'b1, 4'd15, 1'b0})
            $display("FAIL full_ctrl: got v=%b c=%0d o=%b want v=1 c=15 o=0", pkt_valid, dct_count, pkt_ovf);
        else n_pass++;
        n_total++;
        if (dct_buffer !== 30'h15555555) $display("FAIL full_buffer: got %h want 15555555", dct_buffer);
        else n_pass++;
        set_in(0, 2'b00, 0, 1);
        cycle();
        n_total++;
        if (pkt_valid !== 1'b0) $display("FAIL full_drain: got valid=%b want 0", pkt_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [1:0] seq[3] = '{2'b11, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            set_in(1, seq[i], 0, 1);
            cycle();
        end
        set_in(0, 2'b00, 1, 1);
        cycle();
        n_total++;
        if ({pkt_valid, dct_count, dct_buffer} !== {1'b1, 4'd3, 30'h39})
            $display("FAIL flush_partial: got v=%b c=%0d b=%h want v=1 c=3 b=39", pkt_valid, dct_count, dct_buffer);
        else n_pass++;
        set_in(0, 2'b00, 0, 1);
        cycle();
        set_in(0, 2'b00, 1, 1);
        cycle();
        cycle();
        n_total++;
        if (pkt_valid !== 1'b0) $display("FAIL flush_empty: got valid=%b want 0", pkt_valid);
        else n_pass++;
        set_in(1, 2'b11, 1, 1);
        cycle();
        n_total++;
        if ({pkt_valid, dct_count, dct_buffer} !== {1'b1, 4'd1, 30'h3})
            $display("FAIL flush_with_frame: got v=%b c=%0d b=%h want v=1 c=1 b=3", pkt_valid, dct_count, dct_buffer);
        else n_pass++;
        n_total++;
        if (dut_vec() !== mdl_vec()) $display("FAIL flush_model: got %h want %h", dut_vec(), mdl_vec());
        else n_pass++;
        set_in(0, 2'b00, 0, 1);
        cycle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 31; i++) begin
            set_in(1, 2'b01, 0, 0);
            cycle();
            n_total++;
            if (dut_vec() !== mdl_vec()) $display("FAIL ovf_model cyc%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else n_pass++;
        end
        n_total++;
        if ({pkt_valid, dct_count, pkt_ovf} !== {1'b1, 4'd15, 1'b0})
            $display("FAIL ovf_first_held: got v=%b c=%0d o=%b want v=1 c=15 o=0", pkt_valid, dct_count, pkt_ovf);
        else n_pass++;
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
        n_total++;
        if (drop_count !== 16'd1) $display("FAIL ovf_drop_count: got %0d want 1", drop_count);
        else n_pass++;
`endif
        set_in(0, 2'b00, 0, 1);
        cycle();
        n_total++;
        if ({pkt_valid, dct_count, pkt_ovf, dct_buffer} !== {1'b1, 4'd15, 1'b1, 30'h15555555})
            $display("FAIL ovf_second: got v=%b c=%0d o=%b b=%h want v=1 c=15 o=1 b=15555555",
                     pkt_valid, dct_count, pkt_ovf, dct_buffer);
        else n_pass++;
        cycle();
        n_total++;
        if (pkt_valid !== 1'b0) $display("FAIL ovf_drain: got valid=%b want 0", pkt_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pkts = 0, low_run = 0, max_low = 0, ovf_seen = 0, bad = 0;
        for (int i = 0; i < 150; i++) begin
            set_in(1, 2'($urandom_range(0, 3)), 0, 1);
            cycle();
            if (dut_vec() !== mdl_vec()) bad++;
            if (pkt_valid) begin
                pkts++;
                low_run = 0;
                if (pkt_ovf) ovf_seen++;
            end else begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
        end
        n_total++;
        if (pkts !== 10) $display("FAIL b2b_packets: got %0d want 10", pkts);
        else n_pass++;
        n_total++;
        if (max_low > 14) $display("FAIL b2b_gap: got %0d want <=14", max_low);
        else n_pass++;
        n_total++;
        if (ovf_seen !== 0) $display("FAIL b2b_ovf: got %0d want 0", ovf_seen);
        else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL b2b_model: got %0d mismatching cycles want 0", bad);
        else n_pass++;
        set_in(0, 2'b00, 0, 1);
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 5);
            cycle();
            n_total++;
            if (dut_vec() !== mdl_vec()) $display("FAIL rand_model cyc%0d: got %h want %h", i, dut_vec(), mdl_vec());
            else n_pass++;
            if (dut_vec() !== mdl_vec()) break;
        end
`ifdef CORE5_OCI_DCT_DROP_CNT_EN
        n_total++;
        if (drop_count !== 16'(m_drops)) $display("FAIL rand_drop_count: got %0d want %0d", drop_count, m_drops);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 2'b10, 0, 0);
            cycle();
        end
        set_in(0, 2'b00, 1, 0);
        cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 2'b11, 0, 0);
            cycle();
        end
        n_total++;
        if (pkt_valid !== 1'b1) $display("FAIL mid_pending: got valid=%b want 1", pkt_valid);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (dut_vec() !== 36'h0) $display("FAIL mid_reset_outputs: got %h want 0", dut_vec());
        else n_pass++;
        model_reset();
        set_in(0, 2'b00, 0, 1);
        #1;
        reset_n = 1'b1;
        set_in(0, 2'b00, 1, 1);
        cycle();
        set_in(0, 2'b00, 0, 1);
        cycle();
        n_total++;
        if (pkt_valid !== 1'b0) $display("FAIL mid_flush_after_reset: got valid=%b want 0", pkt_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
